// File: rtl/inst_fetch.sv
// Instruction-fetch controller: looks up pc_i in a direct-mapped I-cache and, on a miss,
// refills one word from a byte-wide little-endian memory port before retrying the lookup.
module inst_fetch #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              pc_advance_o,
   output logic [ADDR_W-1:0] ic_raddr_o,
   input  logic              ic_hit_i,
   input  logic [31:0]       ic_inst_i,
   output logic              ic_we_o,
   output logic [ADDR_W-1:0] ic_waddr_o,
   output logic [31:0]       ic_winst_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_valid_i,
   input  logic [7:0]        mem_data_i,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              inst_valid_o
);

   typedef enum logic [1:0] {
      LOOKUP = 2'd0,
      FETCH  = 2'd1,
      WRITE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       buf_q, buf_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic              bubble_s;

   // A flush always kills the IF/ID entry; otherwise refill cycles insert a bubble unless stalled.
   assign bubble_s = flush_i | ~stall_i;

   // Next-state, refill datapath and IF/ID update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      buf_d        = buf_q;
      fetch_pc_d   = fetch_pc_q;
      inst_d       = inst_q;
      pc_d         = pc_q;
      valid_d      = valid_q;
      pc_advance_o = 1'b0;
      mem_req_o    = 1'b0;
      ic_we_o      = 1'b0;
      case (state_q)
         LOOKUP: begin
            if (flush_i) begin
               valid_d = 1'b0;
            end else if (ic_hit_i) begin
               if (!stall_i) begin
                  pc_advance_o = 1'b1;
                  inst_d       = ic_inst_i;
                  pc_d         = pc_i;
                  valid_d      = 1'b1;
               end else begin
                  valid_d = valid_q;
               end
            end else begin
               // A miss starts the refill even under stall; only the bubble waits for !stall_i.
               fetch_pc_d = pc_i;
               cnt_d      = 2'd0;
               state_d    = FETCH;
               valid_d    = stall_i ? valid_q : 1'b0;
            end
         end
         FETCH: begin
            mem_req_o = 1'b1;
            valid_d   = bubble_s ? 1'b0 : valid_q;
            if (mem_valid_i) begin
               buf_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
               cnt_d   = cnt_q + 2'd1;
               state_d = (cnt_q == 2'd3) ? WRITE : FETCH;
            end else begin
               cnt_d = cnt_q;
            end
         end
         WRITE: begin
            ic_we_o = 1'b1;
            valid_d = bubble_s ? 1'b0 : valid_q;
            state_d = LOOKUP;
         end
         default: begin
            state_d = LOOKUP;
         end
      endcase
   end

   // State and IF/ID registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LOOKUP;
         cnt_q      <= 2'd0;
         buf_q      <= 32'h0000_0000;
         fetch_pc_q <= '0;
         inst_q     <= 32'h0000_0000;
         pc_q       <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         fetch_pc_q <= fetch_pc_d;
         inst_q     <= inst_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
      end
   end

   assign ic_raddr_o   = pc_i;
   assign ic_waddr_o   = fetch_pc_q;
   assign ic_winst_o   = buf_q;
   assign mem_addr_o   = fetch_pc_q + ADDR_W'(cnt_q);
   assign inst_o       = inst_q;
   assign pc_o         = pc_q;
   assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a vector table for lookup/stall/flush behaviour plus
// hand-written refill sequences against a small cache and byte-memory model.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        stall_i;
   logic        flush_i;
   logic        pc_advance_o;
   logic [31:0] ic_raddr_o;
   logic        ic_hit_i;
   logic [31:0] ic_inst_i;
   logic        ic_we_o;
   logic [31:0] ic_waddr_o;
   logic [31:0] ic_winst_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_valid_i;
   logic [7:0]  mem_data_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        inst_valid_o;

   inst_fetch #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
      .pc_advance_o(pc_advance_o), .ic_raddr_o(ic_raddr_o), .ic_hit_i(ic_hit_i),
      .ic_inst_i(ic_inst_i), .ic_we_o(ic_we_o), .ic_waddr_o(ic_waddr_o),
      .ic_winst_o(ic_winst_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .inst_o(inst_o),
      .pc_o(pc_o), .inst_valid_o(inst_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        stall;
      logic        flush;
      logic        hit;
      logic [31:0] inst;
      logic        e_adv;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_valid;
   } vec_t;

   vec_t        tbl [10];
   logic [31:0] cmem [logic [31:0]];
   logic [31:0] addr_log [$];
   logic [31:0] req_log [$];
   int          n_pass = 0;
   int          n_total = 0;
   int          we_cnt = 0;
   int          mem_wait = 0;
   int          wait_cnt = 0;
   logic        use_model = 1'b0;
   logic        last_adv;
   logic [31:0] last_waddr;
   logic [31:0] last_winst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0000_1000: return 8'h13;
         32'h0000_1001: return 8'h05;
         32'h0000_1002: return 8'h10;
         32'h0000_1003: return 8'h00;
         default:       return {a[3:0], a[7:4]} ^ 8'hA5;
      endcase
   endfunction

   // One clock: drive model-side inputs, sample pre-edge outputs, clock, return at negedge.
   task automatic step();
      if (use_model) begin
         ic_hit_i  = (cmem.exists(pc_i) != 0);
         ic_inst_i = ic_hit_i ? cmem[pc_i] : 32'h0;
      end
      if (mem_req_o) begin
         req_log.push_back(mem_addr_o);
         if (wait_cnt >= mem_wait) begin
            mem_valid_i = 1'b1;
            mem_data_i  = mem_byte(mem_addr_o);
            wait_cnt    = 0;
            addr_log.push_back(mem_addr_o);
         end else begin
            mem_valid_i = 1'b0;
            mem_data_i  = 8'h00;
            wait_cnt++;
         end
      end else begin
         mem_valid_i = 1'b1;
         mem_data_i  = 8'hEE;
         wait_cnt    = 0;
      end
      #1;
      last_adv = pc_advance_o;
      if (ic_we_o) begin
         we_cnt++;
         last_waddr = ic_waddr_o;
         last_winst = ic_winst_o;
         cmem[ic_waddr_o] = ic_winst_o;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int   n;
      logic bad_deliver;

      tbl[0] = '{32'h04, 1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b1, 32'hAAAA_0001, 32'h04, 1'b1};
      tbl[1] = '{32'h08, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 32'hAAAA_0001, 32'h04, 1'b1};
      tbl[2] = '{32'h08, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 32'hAAAA_0001, 32'h04, 1'b1};
      tbl[3] = '{32'h08, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 32'hAAAA_0001, 32'h04, 1'b1};
      tbl[4] = '{32'h08, 1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 1'b1, 32'hBBBB_0002, 32'h08, 1'b1};
      tbl[5] = '{32'h0C, 1'b0, 1'b1, 1'b1, 32'hCCCC_0003, 1'b0, 32'hBBBB_0002, 32'h08, 1'b0};
      tbl[6] = '{32'h10, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'hBBBB_0002, 32'h08, 1'b0};
      tbl[7] = '{32'h10, 1'b1, 1'b1, 1'b1, 32'hDDDD_0004, 1'b0, 32'hBBBB_0002, 32'h08, 1'b0};
      tbl[8] = '{32'h14, 1'b0, 1'b0, 1'b1, 32'hEEEE_0005, 1'b1, 32'hEEEE_0005, 32'h14, 1'b1};
      tbl[9] = '{32'h18, 1'b1, 1'b0, 1'b1, 32'hFFFF_0006, 1'b0, 32'hEEEE_0005, 32'h14, 1'b1};

      rst = 1'b1; pc_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0;
      ic_hit_i = 1'b0; ic_inst_i = 32'h0; mem_valid_i = 1'b0; mem_data_i = 8'h00;
      #1;
      chk("reset_inst", inst_o, 32'h0);
      chk("reset_pc", pc_o, 32'h0);
      chk("reset_valid", {31'h0, inst_valid_o}, 32'h0);
      chk("reset_req", {31'h0, mem_req_o}, 32'h0);
      chk("reset_we", {31'h0, ic_we_o}, 32'h0);
      chk("reset_adv", {31'h0, pc_advance_o}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         pc_i = tbl[i].pc; stall_i = tbl[i].stall; flush_i = tbl[i].flush;
         ic_hit_i = tbl[i].hit; ic_inst_i = tbl[i].inst;
         step();
         chk($sformatf("tbl%0d_adv", i), {31'h0, last_adv}, {31'h0, tbl[i].e_adv});
         chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].e_inst);
         chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].e_pc);
         chk($sformatf("tbl%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, tbl[i].e_valid});
         chk($sformatf("tbl%0d_req", i), {31'h0, mem_req_o}, 32'h0);
         chk($sformatf("tbl%0d_raddr", i), ic_raddr_o, tbl[i].pc);
      end

      // Cold miss, zero-wait memory: 7 cycles from miss to valid.
      use_model = 1'b1; stall_i = 1'b0; flush_i = 1'b0; mem_wait = 0;
      addr_log.delete(); we_cnt = 0;
      pc_i = 32'h0000_1000;
      step();
      n = 1;
      while (!inst_valid_o && n < 20) begin step(); n++; end
      chk("cold_latency", n, 7);
      chk("cold_addr_n", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         chk($sformatf("cold_addr%0d", i), addr_log[i], 32'h1000 + i);
      chk("cold_we_cnt", we_cnt, 1);
      chk("cold_waddr", last_waddr, 32'h0000_1000);
      chk("cold_winst", last_winst, 32'h0010_0513);
      chk("cold_adv", {31'h0, last_adv}, 32'h1);
      chk("cold_inst", inst_o, 32'h0010_0513);
      chk("cold_pc", pc_o, 32'h0000_1000);

      // Flush after byte 1 of a refill for 0x2000, redirect to 0x3000.
      we_cnt = 0; bad_deliver = 1'b0;
      pc_i = 32'h0000_2000;
      step(); bad_deliver |= inst_valid_o;
      step(); bad_deliver |= inst_valid_o;
      flush_i = 1'b1; pc_i = 32'h0000_3000;
      step();
      chk("flush_adv", {31'h0, last_adv}, 32'h0);
      chk("flush_valid", {31'h0, inst_valid_o}, 32'h0);
      flush_i = 1'b0;
      n = 0;
      while (we_cnt == 0 && n < 10) begin step(); bad_deliver |= inst_valid_o; n++; end
      chk("flush_we_cnt", we_cnt, 1);
      chk("flush_waddr", last_waddr, 32'h0000_2000);
      chk("flush_winst", last_winst, 32'h9585_B5A5);
      chk("flush_no_deliver", {31'h0, bad_deliver}, 32'h0);

      // Slow memory: the lookup at 0x3000 misses; 3 idle cycles before every byte.
      mem_wait = 3; req_log.delete(); we_cnt = 0;
      n = 0;
      while (we_cnt == 0 && n < 40) begin step(); n++; end
      chk("slow_cycles_to_write", n, 18);
      chk("slow_req_n", req_log.size(), 16);
      for (int i = 0; i < 16 && i < req_log.size(); i++)
         chk($sformatf("slow_req%0d", i), req_log[i], 32'h3000 + (i / 4));
      chk("slow_waddr", last_waddr, 32'h0000_3000);
      step();
      chk("slow_adv", {31'h0, last_adv}, 32'h1);
      chk("slow_inst", inst_o, 32'h9585_B5A5);
      chk("slow_pc", pc_o, 32'h0000_3000);
      chk("slow_valid", {31'h0, inst_valid_o}, 32'h1);

      // Address wrap.
      mem_wait = 0; addr_log.delete(); we_cnt = 0;
      pc_i = 32'hFFFF_FFFE;
      n = 0;
      while (we_cnt == 0 && n < 10) begin step(); n++; end
      chk("wrap_addr_n", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         chk("wrap_addr0", addr_log[0], 32'hFFFF_FFFE);
         chk("wrap_addr1", addr_log[1], 32'hFFFF_FFFF);
         chk("wrap_addr2", addr_log[2], 32'h0000_0000);
         chk("wrap_addr3", addr_log[3], 32'h0000_0001);
      end
      chk("wrap_winst", last_winst, 32'hB5A5_5A4A);
      step();
      chk("wrap_inst", inst_o, 32'hB5A5_5A4A);
      chk("wrap_pc", pc_o, 32'hFFFF_FFFE);

      // Reset after two bytes of a refill for 0x5000.
      we_cnt = 0;
      pc_i = 32'h0000_5000;
      step(); step(); step();
      chk("rstmid_req_before", {31'h0, mem_req_o}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rstmid_req", {31'h0, mem_req_o}, 32'h0);
      chk("rstmid_valid", {31'h0, inst_valid_o}, 32'h0);
      chk("rstmid_pc", pc_o, 32'h0);
      @(negedge clk);
      step(); step();
      rst = 1'b0;
      pc_i = 32'h0000_1000;
      step();
      chk("rstmid_we_cnt", we_cnt, 0);
      chk("rstmid_no_entry", {31'h0, (cmem.exists(32'h0000_5000) != 0)}, 32'h0);
      chk("rstmid_adv", {31'h0, last_adv}, 32'h1);
      chk("rstmid_inst", inst_o, 32'h0010_0513);
      chk("rstmid_valid_after", {31'h0, inst_valid_o}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch controller between the PC register and the IF/ID latch.
- Looks up the current PC in the direct-mapped instruction cache.
- On a hit, delivers the 32-bit instruction to a registered IF/ID output.
- On a miss, pulls four bytes from the byte-wide memory port (little-endian), writes the assembled word into the cache, then retries the lookup.

Parameters:
ADDR_W, 32, instruction address width (matches InstAddrBus)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pc_i  in  ADDR_W  current PC from PC register
stall_i  in  1  downstream stall; hold IF/ID outputs
flush_i  in  1  branch redirect; discard delivered/pending instruction
pc_advance_o  out  1  PC register may step (instruction accepted this cycle)
ic_raddr_o  out  ADDR_W  cache read address
ic_hit_i  in  1  cache hit (combinational)
ic_inst_i  in  32  cache read data
ic_we_o  out  1  cache write enable
ic_waddr_o  out  ADDR_W  cache write address
ic_winst_o  out  32  cache write data
mem_req_o  out  1  byte read request, held until mem_valid_i
mem_addr_o  out  ADDR_W  byte address
mem_valid_i  in  1  mem_data_i holds the byte at mem_addr_o
mem_data_i  in  8  read byte
inst_o  out  32  IF/ID instruction
pc_o  out  ADDR_W  IF/ID PC
inst_valid_o  out  1  IF/ID valid

Behaviour:
- Reset: async on rst=1.
  - state=LOOKUP, byte counter=0, assembly buffer=0.
  - All outputs 0: inst_o, pc_o, inst_valid_o, mem_req_o, ic_we_o, pc_advance_o.
  - Reset asserted mid-refill abandons the refill; no cache write occurs.
- ic_raddr_o = pc_i in every state.
- States LOOKUP, FETCH, WRITE.
- LOOKUP:
  - Hit, !stall_i, !flush_i:
    - pc_advance_o=1 (combinational).
    - Next edge: inst_o<=ic_inst_i, pc_o<=pc_i, inst_valid_o<=1.
  - Hit with stall_i: outputs hold, pc_advance_o=0.
  - Miss (!flush_i):
    - Next edge: fetch_pc<=pc_i, cnt<=0, state<=FETCH.
    - If !stall_i, inst_valid_o<=0 (bubble).
    - A miss starts the refill even while stall_i=1.
- FETCH:
  - mem_req_o=1, mem_addr_o=fetch_pc+cnt (mod 2^ADDR_W).
  - On mem_valid_i: buf[8*cnt+:8]<=mem_data_i, cnt<=cnt+1.
  - On cnt==3 with mem_valid_i: state<=WRITE.
  - mem_valid_i outside FETCH is ignored.
  - pc_advance_o=0.
  - inst_valid_o<=0 unless stall_i.
- WRITE (exactly one cycle):
  - ic_we_o=1, ic_waddr_o=fetch_pc, ic_winst_o=buf.
  - mem_req_o=0, pc_advance_o=0.
  - state<=LOOKUP.
- Miss latency: miss cycle, N memory-wait cycles (N≥4), write cycle, hit cycle. Minimum 7 cycles from miss detection to inst_valid_o=1.
- flush_i (any state, priority over stall_i):
  - Next edge inst_valid_o<=0; pc_advance_o=0 that cycle.
  - During FETCH/WRITE the refill of fetch_pc completes and is written to cache; no output is produced for it.
  - The following LOOKUP uses the redirected pc_i.
  - A flush in LOOKUP does not start a refill that cycle.
- stall_i alone never changes inst_o/pc_o/inst_valid_o.
- mem_addr_o and mem_req_o are stable while waiting for mem_valid_i.

Test Plan:
- Reset mid-refill:
  - Stimulus: assert rst after 2 bytes.
  - Response: mem_req_o=0 immediately; ic_we_o never asserted; state LOOKUP after release.
- Cold miss, zero-wait memory:
  - Stimulus: pc_i=0x0000_1000, bytes 0x13,0x05,0x10,0x00.
  - Response:
    - mem_addr_o steps 0x1000..0x1003.
    - ic_we_o=1 one cycle with ic_winst_o=0x00100513, ic_waddr_o=0x1000.
    - Next edge: inst_o=0x00100513, pc_o=0x1000, inst_valid_o=1, pc_advance_o=1 in hit cycle.
- Hit stream with stall:
  - Stimulus: cached pc 0x4,0x8; stall_i=1 for 3 cycles at 0x8.
  - Response: inst_o/pc_o hold at 0x4 entry; pc_advance_o=0 during stall; 0x8 delivered the cycle after stall_i drops.
- Slow memory:
  - Stimulus: mem_valid_i after 3 idle cycles per byte.
  - Response: mem_addr_o constant during waits; WRITE occurs after 4th valid only.
- Flush during FETCH:
  - Stimulus: miss at 0x2000; flush_i with pc_i=0x3000 after byte 1.
  - Response: cache written for 0x2000; no inst_valid_o for 0x2000; next lookup at 0x3000.
- Address wrap:
  - Stimulus: miss at 0xFFFF_FFFE.
  - Response: mem_addr_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
